// File: rtl/de1_soc_pkg.sv
// Board-level constants shared by the DE1-SoC support blocks.
//   DE1_SOC_NUM_KEYS         number of KEY push-buttons on the board
//   DE1_SOC_CLK_HZ           system clock frequency
//   DE1_SOC_DEBOUNCE_CYCLES  1 ms debounce window at DE1_SOC_CLK_HZ
package de1_soc_pkg;

    localparam int unsigned DE1_SOC_NUM_KEYS        = 4;
    localparam int unsigned DE1_SOC_CLK_HZ          = 50_000_000;
    localparam int unsigned DE1_SOC_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/de1_soc_debounce_bit.sv
// One button: 2-FF synchroniser, debounce counter, stable-state register and
// registered press/release strobes.
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   key_n          raw pin, asynchronous, active-low
//   pressed        debounced level, active-high
//   press_pulse    1-cycle strobe on pressed 0->1
//   release_pulse  1-cycle strobe on pressed 1->0
module de1_soc_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_n;
    logic             stable_n_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             flip;

    // Any cycle of agreement with the stable state restarts the window.
    always_comb begin
        cnt_next      = '0;
        stable_n_next = stable_n;
        flip          = 1'b0;
        if (sync2 != stable_n) begin
            if (cnt == CNT_MAX) begin
                flip          = 1'b1;
                stable_n_next = sync2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            stable_n      <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= key_n;
            sync2         <= sync1;
            stable_n      <= stable_n_next;
            cnt           <= cnt_next;
            press_pulse   <= flip & ~sync2;
            release_pulse <= flip & sync2;
        end
    end

    assign pressed = ~stable_n;

endmodule

// File: rtl/de1_soc_button_debounce.sv
// Synchronises and debounces the active-low KEY inputs and presents an
// active-high level vector for the button PIO in_port, plus per-button
// one-cycle press/release strobes.
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   key_n          raw KEY pins, active-low
//   pressed        debounced levels, active-high (to PIO in_port)
//   press_pulse    per-bit strobe on pressed 0->1
//   release_pulse  per-bit strobe on pressed 1->0
module de1_soc_button_debounce
    import de1_soc_pkg::*;
#(
    parameter int unsigned WIDTH           = DE1_SOC_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DE1_SOC_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        de1_soc_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk          (clk),
            .reset_n      (reset_n),
            .key_n        (key_n[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_de1_soc_button_debounce.sv
module tb_de1_soc_button_debounce;

    localparam int unsigned W  = 4;
    localparam int unsigned DC = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] key_n;
    logic [W-1:0] pressed;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    int checks = 0;
    int errors = 0;

    de1_soc_button_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] ep,
                           input logic [W-1:0] epp, input logic [W-1:0] erp);
        chk({tag, ".pressed"}, pressed, ep);
        chk({tag, ".press_pulse"}, press_pulse, epp);
        chk({tag, ".release_pulse"}, release_pulse, erp);
    endtask

    initial begin
        // Reset with all keys held.
        reset_n = 1'b0;
        key_n   = 4'b0000;
        step(2);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000);

        // Release reset between edges; next edge is E0, flip on E5.
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk_all("hold_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step(1);
        chk_all("hold_rise", 4'b1111, 4'b1111, 4'b0000);
        step(1);
        chk_all("hold_after", 4'b1111, 4'b0000, 4'b0000);

        // Release everything.
        key_n = 4'b1111;
        step(5);
        chk_all("rel_all_wait", 4'b1111, 4'b0000, 4'b0000);
        step(1);
        chk_all("rel_all", 4'b0000, 4'b0000, 4'b1111);
        step(1);
        chk_all("rel_all_after", 4'b0000, 4'b0000, 4'b0000);

        // Bounce on bit 0: two-cycle runs never fill the 4-cycle window.
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) key_n[0] = ~key_n[0];
            step(1);
            chk_all("bounce", 4'b0000, 4'b0000, 4'b0000);
        end
        key_n[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_all("bounce_settle", 4'b0000, 4'b0000, 4'b0000);
        end

        // Press then release bit 2.
        key_n = 4'b1011;
        step(5);
        chk_all("b2_press_wait", 4'b0000, 4'b0000, 4'b0000);
        step(1);
        chk_all("b2_press", 4'b0100, 4'b0100, 4'b0000);
        step(1);
        chk_all("b2_press_after", 4'b0100, 4'b0000, 4'b0000);
        key_n = 4'b1111;
        step(5);
        chk_all("b2_rel_wait", 4'b0100, 4'b0000, 4'b0000);
        step(1);
        chk_all("b2_rel", 4'b0000, 4'b0000, 4'b0100);
        step(1);
        chk_all("b2_rel_after", 4'b0000, 4'b0000, 4'b0000);

        // Glitch on bit 1: three low samples (one short of the window),
        // one high sample, then low for good.
        key_n = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_all("glitch_low", 4'b0000, 4'b0000, 4'b0000);
        end
        key_n = 4'b1111;
        step(1);
        chk_all("glitch_high", 4'b0000, 4'b0000, 4'b0000);
        key_n = 4'b1101;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk_all("glitch_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step(1);
        chk_all("glitch_rise", 4'b0010, 4'b0010, 4'b0000);
        key_n = 4'b1111;
        step(6);
        chk_all("glitch_rel", 4'b0000, 4'b0000, 4'b0010);
        step(1);

        // Simultaneous press on bits 1 and 3.
        key_n = 4'b0101;
        step(5);
        chk_all("simul_wait", 4'b0000, 4'b0000, 4'b0000);
        step(1);
        chk_all("simul_rise", 4'b1010, 4'b1010, 4'b0000);
        step(1);
        chk_all("simul_after", 4'b1010, 4'b0000, 4'b0000);
        key_n = 4'b1111;
        step(6);
        chk_all("simul_rel", 4'b0000, 4'b0000, 4'b1010);
        step(1);
        chk_all("simul_rel_after", 4'b0000, 4'b0000, 4'b0000);

        // Reset mid-count on bit 3.
        key_n = 4'b0111;
        step(3);
        reset_n = 1'b0;
        #1;
        chk_all("midrst_assert", 4'b0000, 4'b0000, 4'b0000);
        step(2);
        chk_all("midrst_held", 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk_all("midrst_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        step(1);
        chk_all("midrst_rise", 4'b1000, 4'b1000, 4'b0000);

        // Asynchronous clear while a pulse and a level are both high.
        reset_n = 1'b0;
        #1;
        chk_all("async_clear", 4'b0000, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
